// File: rtl/experiment2.sv
// experiment2: self-contained RLS system-identification experiment.
// An LFSR drives a +/-1 excitation into a fixed 2-tap plant. A 2-tap RLS
// filter (lambda = 1) estimates the plant. After each iteration both
// weights are streamed out on x with a one-cycle write strobe per word.
// All datapath values are signed Q(nBits-16).15.
module experiment2 #(
  parameter int N     = 16,
  parameter int M     = 2,
  parameter int nBits = 32,
  parameter int B     = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             write,
  output logic [nBits-1:0] x
);

  localparam int FRAC = 15;
  // The divider produces one quotient bit for each bit of (num << FRAC).
  localparam int DW   = nBits + FRAC;
  localparam int CW   = $clog2(DW + 1);
  localparam int NW   = $clog2(N + 1);

  localparam logic signed [nBits-1:0] ONE    = nBits'(32'sd32768);
  localparam logic signed [nBits-1:0] P_INIT = nBits'(1 << (B + FRAC));
  localparam logic signed [nBits-1:0] C_CUR  = nBits'(32'sd16384);
  localparam logic signed [nBits-1:0] C_PREV = nBits'(-32'sd8192);

  typedef enum logic [3:0] {
    S_IDLE, S_GEN, S_PI, S_ALPHA, S_DIV, S_ERR,
    S_UPD_W, S_UPD_P, S_OUT0, S_OUT1, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [15:0]             lfsr_reg;
  logic [NW-1:0]           iter_reg;
  logic signed [nBits-1:0] u_reg  [M];   // u_reg[0] = u[n], u_reg[1] = u[n-1]
  logic signed [nBits-1:0] d_reg;
  logic signed [nBits-1:0] w_reg  [M];
  logic signed [nBits-1:0] p_reg  [M][M];
  logic signed [nBits-1:0] pi_reg [M];
  logic signed [nBits-1:0] k_reg  [M];
  logic signed [nBits-1:0] alpha_reg;
  logic signed [nBits-1:0] e_reg;

  // Sequential restoring divider state.
  logic [nBits-1:0]        rem_reg;
  logic [DW-1:0]           dq_reg;
  logic [CW-1:0]           div_cnt_reg;
  logic                    div_sel_reg;
  logic                    div_neg_reg;

  logic                    write_reg;
  logic [nBits-1:0]        x_reg;

  // Fixed-point product: full-width multiply, arithmetic shift by FRAC,
  // truncated back to nBits.
  function automatic logic signed [nBits-1:0] qmul(
    input logic signed [nBits-1:0] a,
    input logic signed [nBits-1:0] b
  );
    logic signed [2*nBits-1:0] ax, bx, prod;
    ax   = {{nBits{a[nBits-1]}}, a};
    bx   = {{nBits{b[nBits-1]}}, b};
    prod = ax * bx;
    return nBits'(prod >>> FRAC);
  endfunction

  // Excitation and plant.
  logic                    lfsr_fb;
  logic [15:0]             lfsr_next;
  logic signed [nBits-1:0] u_new;
  logic signed [nBits-1:0] d_gen;

  assign lfsr_fb   = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];
  assign lfsr_next = {lfsr_fb, lfsr_reg[15:1]};
  assign u_new     = lfsr_next[0] ? ONE : -ONE;
  assign d_gen     = qmul(C_CUR, u_new) + qmul(C_PREV, u_reg[0]);

  // Per-tap arithmetic for the RLS recursion.
  logic signed [nBits-1:0] pi_next [M];
  logic signed [nBits-1:0] uy      [M];
  logic signed [nBits-1:0] wu      [M];
  logic signed [nBits-1:0] w_next  [M];
  logic signed [nBits-1:0] p_next  [M][M];

  genvar gi, gj;
  generate
    for (gi = 0; gi < M; gi++) begin : g_tap
      assign pi_next[gi] = qmul(p_reg[gi][0], u_reg[0]) + qmul(p_reg[gi][1], u_reg[1]);
      assign uy[gi]      = qmul(u_reg[gi], pi_reg[gi]);
      assign wu[gi]      = qmul(w_reg[gi], u_reg[gi]);
      assign w_next[gi]  = w_reg[gi] + qmul(k_reg[gi], e_reg);
      for (gj = 0; gj < M; gj++) begin : g_col
        assign p_next[gi][gj] = p_reg[gi][gj] - qmul(k_reg[gi], pi_reg[gj]);
      end
    end
  endgenerate

  logic signed [nBits-1:0] alpha_next;
  logic signed [nBits-1:0] e_next;

  assign alpha_next = ONE + uy[0] + uy[1];
  assign e_next     = d_reg - (wu[0] + wu[1]);

  // Divider: works on |num| << FRAC and fixes the sign at the end, which
  // gives truncation toward zero. alpha >= 1.0 keeps the quotient and the
  // partial remainder within nBits.
  logic signed [nBits-1:0] div_num;
  logic [nBits-1:0]        num_mag;
  logic [nBits:0]          rem_shift;
  logic [nBits:0]          trial;
  logic                    q_bit;
  logic [nBits-1:0]        rem_step;
  logic [DW-1:0]           dq_step;
  logic [nBits-1:0]        quot;
  logic signed [nBits-1:0] k_result;
  logic                    div_last;

  // k0 is loaded on leaving ALPHA, k1 at the end of the k0 division.
  assign div_num   = (state_reg == S_DIV) ? pi_reg[1] : pi_reg[0];
  assign num_mag   = div_num[nBits-1] ? -div_num : div_num;
  assign rem_shift = {rem_reg, dq_reg[DW-1]};
  assign trial     = rem_shift - {1'b0, alpha_reg};
  assign q_bit     = ~trial[nBits];
  assign rem_step  = nBits'(q_bit ? trial : rem_shift);
  assign dq_step   = {dq_reg[DW-2:0], q_bit};
  assign quot      = dq_step[nBits-1:0];
  assign k_result  = div_neg_reg ? -quot : quot;
  assign div_last  = (div_cnt_reg == CW'(DW - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state sequencing of one RLS iteration.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  state_next = S_GEN;
      S_GEN:   state_next = S_PI;
      S_PI:    state_next = S_ALPHA;
      S_ALPHA: state_next = S_DIV;
      S_DIV:   if (div_last && div_sel_reg) state_next = S_ERR;
      S_ERR:   state_next = S_UPD_W;
      S_UPD_W: state_next = S_UPD_P;
      S_UPD_P: state_next = S_OUT0;
      S_OUT0:  state_next = S_OUT1;
      S_OUT1:  state_next = (iter_reg == NW'(N - 1)) ? S_DONE : S_GEN;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and output registers, advanced by the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_reg    <= 16'hACE1;
      iter_reg    <= '0;
      d_reg       <= '0;
      alpha_reg   <= '0;
      e_reg       <= '0;
      rem_reg     <= '0;
      dq_reg      <= '0;
      div_cnt_reg <= '0;
      div_sel_reg <= 1'b0;
      div_neg_reg <= 1'b0;
      write_reg   <= 1'b0;
      x_reg       <= '0;
      for (int i = 0; i < M; i++) begin
        u_reg[i]  <= '0;
        w_reg[i]  <= '0;
        pi_reg[i] <= '0;
        k_reg[i]  <= '0;
        for (int j = 0; j < M; j++) p_reg[i][j] <= (i == j) ? P_INIT : '0;
      end
    end else begin
      write_reg <= 1'b0;
      case (state_reg)
        S_GEN: begin
          lfsr_reg <= lfsr_next;
          u_reg[0] <= u_new;
          u_reg[1] <= u_reg[0];
          d_reg    <= d_gen;
        end
        S_PI: begin
          for (int i = 0; i < M; i++) pi_reg[i] <= pi_next[i];
        end
        S_ALPHA: begin
          alpha_reg   <= alpha_next;
          rem_reg     <= '0;
          dq_reg      <= {num_mag, {FRAC{1'b0}}};
          div_neg_reg <= div_num[nBits-1];
          div_cnt_reg <= '0;
          div_sel_reg <= 1'b0;
        end
        S_DIV: begin
          if (!div_last) begin
            rem_reg     <= rem_step;
            dq_reg      <= dq_step;
            div_cnt_reg <= div_cnt_reg + CW'(1);
          end else begin
            k_reg[div_sel_reg] <= k_result;
            if (!div_sel_reg) begin
              rem_reg     <= '0;
              dq_reg      <= {num_mag, {FRAC{1'b0}}};
              div_neg_reg <= div_num[nBits-1];
              div_cnt_reg <= '0;
              div_sel_reg <= 1'b1;
            end
          end
        end
        S_ERR: e_reg <= e_next;
        S_UPD_W: begin
          for (int i = 0; i < M; i++) w_reg[i] <= w_next[i];
        end
        S_UPD_P: begin
          for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) p_reg[i][j] <= p_next[i][j];
          // Registered outputs: this word appears during OUT0.
          x_reg     <= w_reg[0];
          write_reg <= 1'b1;
        end
        S_OUT0: begin
          x_reg     <= w_reg[1];
          write_reg <= 1'b1;
        end
        S_OUT1: iter_reg <= iter_reg + NW'(1);
        default: ;
      endcase
    end
  end

  assign write = write_reg;
  assign x     = x_reg;

endmodule

// File: tb/tb_experiment2.sv
// Bench for experiment2: a plain-arithmetic RLS reference produces the
// expected weight stream; the DUT stream is compared word for word, plus
// reset behaviour, strobe pairing, latency, convergence and post-DONE idle.
module tb_experiment2;

  localparam int N      = 16;
  localparam int NBITS  = 32;
  localparam int NWORDS = 2 * N;
  localparam int ITER_MAX = 4 * NBITS + 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             write;
  logic [NBITS-1:0] x;

  int vectors = 0;
  int miscompares = 0;
  int exp_w [NWORDS];
  int got_w [NWORDS];

  experiment2 #(.N(N), .M(2), .nBits(NBITS), .B(2)) dut (
    .clk   (clk),
    .reset (reset),
    .write (write),
    .x     (x)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input longint obs, input longint expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int qm(input int a, input int b);
    longint pr;
    pr = longint'(a) * longint'(b);
    return int'(pr >>> 15);
  endfunction

  // Reference RLS experiment written straight from the update equations.
  task automatic build_model();
    int lfsr, fb, u_prev;
    int uv [2];
    int w [2];
    int p [2][2];
    int pv [2];
    int k [2];
    int alpha, d, e;
    lfsr = 'hACE1;
    u_prev = 0;
    w = '{0, 0};
    p = '{'{131072, 0}, '{0, 131072}};
    for (int n = 0; n < N; n++) begin
      fb = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
      lfsr = (lfsr >> 1) | (fb << 15);
      uv[0] = (lfsr & 1) ? 32768 : -32768;
      uv[1] = u_prev;
      d = qm(16384, uv[0]) + qm(-8192, uv[1]);
      for (int i = 0; i < 2; i++) pv[i] = qm(p[i][0], uv[0]) + qm(p[i][1], uv[1]);
      alpha = 32768 + qm(uv[0], pv[0]) + qm(uv[1], pv[1]);
      for (int i = 0; i < 2; i++) k[i] = int'((longint'(pv[i]) <<< 15) / longint'(alpha));
      e = d - (qm(w[0], uv[0]) + qm(w[1], uv[1]));
      for (int i = 0; i < 2; i++) w[i] = w[i] + qm(k[i], e);
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) p[i][j] = p[i][j] - qm(k[i], pv[j]);
      exp_w[2*n]   = w[0];
      exp_w[2*n+1] = w[1];
      u_prev = uv[0];
    end
  endtask

  function automatic int sx(input logic [NBITS-1:0] v);
    return int'(signed'(v));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Collect nwords strobes from release, checking each against the model.
  task automatic run_stream(input int nwords);
    int seen, cyc, budget;
    bit prev;
    seen = 0;
    cyc = 0;
    prev = 1'b0;
    budget = nwords * ITER_MAX + 50;
    while (seen < nwords && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (write) begin
        if (seen == 0) check_value("first_write_latency_ok", longint'(cyc <= ITER_MAX), 1);
        $display("word %0d: x=%0d expected=%0d cycle=%0d", seen, sx(x), exp_w[seen], cyc);
        check_value($sformatf("word%0d", seen), sx(x), exp_w[seen]);
        check_value($sformatf("pair_shape%0d", seen), longint'(prev), seen % 2);
        got_w[seen] = sx(x);
        seen++;
      end
      prev = write;
    end
    check_value("stream_count", seen, nwords);
    if (seen >= 2) begin
      check_value("it0_w0_near_0p4", longint'(iabs(got_w[0] - 13106) <= 2), 1);
      check_value("it0_w1_zero", got_w[1], 0);
    end
  endtask

  initial begin
    int hold, offs, extra, changes;
    logic [NBITS-1:0] x_last;
    build_model();

    // Reset hold: outputs quiet throughout.
    reset = 1'b0;
    hold = $urandom_range(3, 10);
    repeat (hold) begin
      @(negedge clk);
      check_value("rst_write", write, 0);
      check_value("rst_x", sx(x), 0);
    end
    reset = 1'b1;
    run_stream(10);

    // Iteration 5 is now under way; drop reset somewhere in its divisions.
    offs = $urandom_range(4, 90);
    repeat (offs) @(negedge clk);
    $display("mid-run reset %0d cycles after word 9", offs);
    reset = 1'b0;
    #1;
    check_value("midrst_write", write, 0);
    check_value("midrst_x", sx(x), 0);
    @(negedge clk);
    check_value("midrst_hold_write", write, 0);
    reset = 1'b1;

    run_stream(NWORDS);
    check_value("final_w0_near_0p5", longint'(iabs(got_w[NWORDS-2] - 16384) <= 328), 1);
    check_value("final_w1_near_m0p25", longint'(iabs(got_w[NWORDS-1] + 8192) <= 328), 1);

    // After DONE: no more strobes and x frozen on the final w1.
    extra = 0;
    changes = 0;
    x_last = x;
    repeat (1000) begin
      @(negedge clk);
      if (write) extra++;
      if (x !== x_last) changes++;
      x_last = x;
    end
    check_value("post_done_strobes", extra, 0);
    check_value("post_done_x_changes", changes, 0);
    check_value("post_done_x", sx(x), exp_w[NWORDS-1]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
